seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
// - Reads a multiplexed, active-low 7-segment display bus and rebuilds the hex digits it shows.
//   It is the inverse of the team's BCD/hex-to-7-segment encoder.
// - Samples the segment lines and digit anodes, and commits a digit only after it has been stable.
// - Assembles one full frame of NUM_DIGITS nibbles and hands it off over a valid/ready handshake.
// - Used for loop-back self-check of the display path and for scraping an external display.
// PARAMETERS
// - NUM_DIGITS     4   number of multiplexed digits (anode lines), >=1
// - STABLE_CYCLES  8   consecutive identical samples required before a digit commits, >=2
// - CNT_W  $clog2(STABLE_CYCLES+1)   stability counter width (localparam, not overridable)
// PORTS
// - clk          in   1             single system clock, rising edge
// - rst_n        in   1             synchronous, active-low reset
// - seg_n        in   7             segments, 0 = lit; bit0=a ... bit6=g
// - an_n         in   NUM_DIGITS    digit enables, active-low, one-hot when valid
// - frame_data   out  4*NUM_DIGITS  nibble of digit k at [4k+3:4k]
// - frame_blank  out  NUM_DIGITS    1 = digit k was blank (all segments off); its nibble is 0
// - frame_valid  out  1             frame_data/frame_blank hold a frame
// - frame_ready  in   1             consumer accepts the frame when valid&&ready
// - pattern_err  out  1             1-cycle pulse: an unrecognised pattern became stable
// - frame_ovr    out  1             1-cycle pulse: a completed frame was dropped while one was pending
// - err_count    out  8             saturating error count (only with SEG7_ERR_COUNT_EN)
// BEHAVIOUR
// - Reset: all outputs 0; captured mask 0; FSM in S_IDLE; synchroniser flops reset to all-ones.
// - Input stage: seg_n and an_n each pass through a 2-flop synchroniser (2 cycles of latency).
// - A sample is valid only when exactly one bit of an_n is 0. That bit gives digit index k.
// - FSM, evaluated once per cycle on the synchronised sample:
//   - S_IDLE: on a valid sample, go to S_TRACK with cnt=1 and latch (k, pattern). Otherwise stay.
//   - S_TRACK, same (k, pattern): cnt++. When cnt reaches STABLE_CYCLES, commit and go to S_HOLD.
//   - S_TRACK, different valid sample: restart, cnt=1 and latch the new (k, pattern).
//   - S_TRACK, invalid sample: go to S_IDLE with cnt=0.
//   - S_HOLD, same (k, pattern): stay. There is exactly one commit per dwell.
//   - S_HOLD, change: behaves exactly like S_TRACK on a change.
// - Commit:
//   - Pattern found in the 16-entry hex table: store the nibble in slot k, clear blank[k], set captured[k].
//   - Pattern 7'b1111111: store nibble 0 in slot k, set blank[k], set captured[k].
//   - Any other pattern: pulse pattern_err and leave slot k and captured[k] unchanged.
// - Hex table (seg_n[6:0]):
//   - 0=1000000  1=1111001  2=0100100  3=0110000
//   - 4=0011001  5=0010010  6=0000010  7=1111000
//   - 8=0000000  9=0010000  A=0001000  b=0000011
//   - C=1000110  d=0100001  E=0000110  F=0001110
// - Frame complete: when captured becomes all-ones, including on the commit cycle itself, the frame is done.
//   Captured clears on the next cycle.
//   - frame_valid=0: load the output registers and set frame_valid=1 on the next cycle.
//   - frame_valid=1 and frame_ready=1 in the same cycle: load the new frame; frame_valid stays 1.
//   - frame_valid=1 and frame_ready=0: drop the new frame, pulse frame_ovr, keep the held frame stable.
// - Handshake rules:
//   - frame_valid stays high and frame_data/frame_blank stay stable until valid&&ready.
//   - On valid&&ready with no new frame, frame_valid drops on the next cycle.
// - Commit-to-frame_valid latency is 1 cycle.
// - Minimum sample-to-commit latency is 2 sync cycles + STABLE_CYCLES samples.
// - Reset asserted mid-dwell or mid-handshake: all state is discarded and the held frame is lost.
// CONFIGURATION
// - SEG7_ERR_COUNT_EN defined:
//   - err_count increments on each pattern_err pulse and saturates at 255.
//   - It clears only on reset.
// - SEG7_ERR_COUNT_EN undefined: the err_count port exists but is tied to 0; pattern_err is unaffected.
// STRUCTURE
// - seg7_pkg:
//   - SEG_HEX[16] pattern constants and SEG_BLANK.
//   - typedef enum logic [1:0] {S_IDLE,S_TRACK,S_HOLD} seg7_rd_state_t.
// - Sub-module seg7_pattern_decode: combinational, seg_n -> {hit, blank, nibble[3:0]}, using SEG_HEX.
// - Top level: synchroniser, one-hot check/index, FSM, captured mask, frame holding register.
// TESTING
// - Test 1: NUM_DIGITS=4. Scan "1","2","3","4" on digits 0..3, 20 cycles each.
//   - Expect frame_data=16'h4321, frame_blank=0, frame_valid=1, then hold until ready.
// - Test 2: Dwell 7 cycles (STABLE_CYCLES-1) on each digit.
//   - Expect no commit and frame_valid to stay 0.
// - Test 3: Drive seg_n=7'b1010101 stable on digit 2.
//   - Expect one pattern_err pulse per dwell, and slot 2 not captured.
//   - With SEG7_ERR_COUNT_EN, err_count increments by 1 per dwell.
// - Test 4: Drive an_n=4'b0011 (two digits on) for 50 cycles.
//   - Expect no commits, no errors, and the FSM to stay in S_IDLE.
// - Test 5: Hold frame_ready=0 over a full second frame.
//   - Expect frame_ovr pulse and the first frame unchanged.
//   - Then drive ready=1 in the cycle a third frame completes: expect the third frame loaded and valid to stay 1.
// - Test 6: Blank digit 1 (7'h7F), then assert rst_n=0 mid-scan.
//   - Expect blank[1]=1 and nibble 0 before the reset.
//   - After reset, expect all outputs 0 and the captured mask cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan reader.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} seg7_rd_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder.
// hit = pattern is one of the 16 hex glyphs; blank = all segments off.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    // Table lookup; glyphs are unique so at most one entry matches.
    always_comb begin
        hit    = 1'b0;
        blank  = (seg_n == SEG_BLANK);
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_HEX[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low 7-segment bus back into hex nibbles and
// hands complete frames out over a valid/ready handshake.
// Optional feature: define SEG7_ERR_COUNT_EN for a saturating pattern error counter.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    pattern_err,
    output logic                    frame_ovr,
    output logic [7:0]              err_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0]   an_s1, an_s2;
    logic [NUM_DIGITS-1:0]   an_act;
    logic                    sample_valid;
    logic [IDX_W-1:0]        sample_idx;

    seg7_rd_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              pat_q, pat_d;
    logic                    same, commit;

    logic                    dec_hit, dec_blank;
    logic [3:0]              dec_nibble;

    logic [4*NUM_DIGITS-1:0] slot_q, slot_d;
    logic [NUM_DIGITS-1:0]   sblank_q, sblank_d;
    logic [NUM_DIGITS-1:0]   captured_q, captured_d, cap_next;
    logic                    frame_done, err_d;

    logic [4*NUM_DIGITS-1:0] fdata_q, fdata_d;
    logic [NUM_DIGITS-1:0]   fblank_q, fblank_d;
    logic                    fvalid_q, fvalid_d;
    logic                    ovr_q, ovr_d;
    logic                    err_q;

    // Two-flop synchronisers; idle to all-ones (nothing lit, no digit selected).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    // Valid sample: exactly one anode low; its position is the digit index.
    always_comb begin
        an_act       = ~an_s2;
        sample_valid = $onehot(an_act);
        sample_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_act[i]) sample_idx = IDX_W'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .seg_n  (seg_s2),
        .hit    (dec_hit),
        .blank  (dec_blank),
        .nibble (dec_nibble)
    );

    // Dwell tracker state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
        end
    end

    // Dwell tracker next state; commit fires on the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        commit  = 1'b0;
        same    = sample_valid && (sample_idx == idx_q) && (seg_s2 == pat_q);
        unique case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_W'(1);
                    idx_d   = sample_idx;
                    pat_d   = seg_s2;
                end
            end
            S_TRACK, S_HOLD: begin
                if (!sample_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_W'(1);
                    idx_d   = sample_idx;
                    pat_d   = seg_s2;
                end else if (state_q == S_TRACK) begin
                    if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        cnt_d   = CNT_W'(STABLE_CYCLES);
                        commit  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slot capture and frame hand-off; a frame completing on the commit cycle counts.
    always_comb begin
        slot_d   = slot_q;
        sblank_d = sblank_q;
        cap_next = captured_q;
        err_d    = 1'b0;
        fdata_d  = fdata_q;
        fblank_d = fblank_q;
        fvalid_d = fvalid_q;
        ovr_d    = 1'b0;
        if (commit) begin
            if (dec_hit || dec_blank) begin
                slot_d[4*idx_q +: 4] = dec_hit ? dec_nibble : 4'h0;
                sblank_d[idx_q]      = dec_blank;
                cap_next[idx_q]      = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        frame_done = &cap_next;
        captured_d = frame_done ? '0 : cap_next;
        if (frame_done) begin
            if (!fvalid_q || frame_ready) begin
                fdata_d  = slot_d;
                fblank_d = sblank_d;
                fvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (fvalid_q && frame_ready) begin
            fvalid_d = 1'b0;
        end
    end

    // Slot, mask and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q     <= '0;
            sblank_q   <= '0;
            captured_q <= '0;
            fdata_q    <= '0;
            fblank_q   <= '0;
            fvalid_q   <= 1'b0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            sblank_q   <= sblank_d;
            captured_q <= captured_d;
            fdata_q    <= fdata_d;
            fblank_q   <= fblank_d;
            fvalid_q   <= fvalid_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of rejected patterns, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign frame_data  = fdata_q;
    assign frame_blank = fblank_q;
    assign frame_valid = fvalid_q;
    assign frame_ovr   = ovr_q;
    assign pattern_err = err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seg7_scan_reader;
    import seg7_pkg::*;

    // Independent glyph constants for the digits used below.
    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110, GOFF = 7'b1111111, GBAD = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] frame_data;
    logic [3:0]  frame_blank;
    logic        frame_valid;
    logic        frame_ready;
    logic        pattern_err;
    logic        frame_ovr;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int err_pulses = 0;
    int ovr_pulses = 0;
    int e0, o0, nonidle;

    seg7_scan_reader #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_data  (frame_data),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pattern_err (pattern_err),
        .frame_ovr   (frame_ovr),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle outputs.
    always @(posedge clk) begin
        if (pattern_err) err_pulses <= err_pulses + 1;
        if (frame_ovr)   ovr_pulses <= ovr_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [6:0] pat);
        an_n  = ~(4'b0001 << d);
        seg_n = pat;
    endtask

    task automatic dwell(input int d, input logic [6:0] pat, input int n);
        drive(d, pat);
        tick(n);
    endtask

    task automatic idle(input int n);
        an_n  = 4'b1111;
        seg_n = GOFF;
        tick(n);
    endtask

    initial begin
        rst_n = 1'b0; an_n = 4'b1111; seg_n = GOFF; frame_ready = 1'b0;
        tick(3);
        chk("rst_data", 32'(frame_data), 32'h0);
        chk("rst_blank", 32'(frame_blank), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_errcnt", 32'(err_count), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Test 1: "1234" on digits 0..3, commit-to-valid latency on the last digit.
        dwell(0, G1, 20);
        dwell(1, G2, 20);
        dwell(2, G3, 20);
        drive(3, G4);
        tick(9);
        chk("t1_valid_before_commit", 32'(frame_valid), 32'h0);
        tick(1);
        chk("t1_valid_after_commit", 32'(frame_valid), 32'h1);
        tick(10);
        idle(5);
        chk("t1_data", 32'(frame_data), 32'h4321);
        chk("t1_blank", 32'(frame_blank), 32'h0);
        chk("t1_valid_hold", 32'(frame_valid), 32'h1);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        chk("t1_valid_drop", 32'(frame_valid), 32'h0);

        // Test 2: dwell one short of the threshold on every digit.
        dwell(0, G1, 7);
        dwell(1, G2, 7);
        dwell(2, G3, 7);
        dwell(3, G4, 7);
        idle(12);
        chk("t2_valid", 32'(frame_valid), 32'h0);
        chk("t2_captured", 32'(dut.captured_q), 32'h0);

        // Test 3: unknown pattern on digit 2, two separate dwells.
        e0 = err_pulses;
        dwell(2, GBAD, 20);
        idle(5);
        chk("t3_err_first", 32'(err_pulses - e0), 32'd1);
        dwell(2, GBAD, 20);
        idle(5);
        chk("t3_err_second", 32'(err_pulses - e0), 32'd2);
        chk("t3_captured", 32'(dut.captured_q), 32'h0);
`ifdef SEG7_ERR_COUNT_EN
        chk("t3_errcnt", 32'(err_count), 32'd2);
`else
        chk("t3_errcnt", 32'(err_count), 32'd0);
`endif
        dwell(0, GA, 20);
        dwell(1, GB, 20);
        dwell(3, GF, 20);
        idle(5);
        chk("t3_no_frame", 32'(frame_valid), 32'h0);
        chk("t3_mask", 32'(dut.captured_q), 32'b1011);

        // Test 4: two anodes on at once for 50 cycles.
        e0 = err_pulses;
        nonidle = 0;
        an_n = 4'b0011;
        seg_n = G8;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (dut.state_q != S_IDLE) nonidle++;
        end
        idle(3);
        chk("t4_fsm_idle", 32'(nonidle), 32'd0);
        chk("t4_no_err", 32'(err_pulses - e0), 32'd0);
        chk("t4_mask", 32'(dut.captured_q), 32'b1011);
        dwell(2, G7, 20);
        idle(3);
        chk("t4_frame_valid", 32'(frame_valid), 32'h1);
        chk("t4_frame_data", 32'(frame_data), 32'hF7BA);

        // Test 5: second frame dropped while ready is low, third loaded on ready.
        o0 = ovr_pulses;
        dwell(0, G5, 20);
        dwell(1, G6, 20);
        dwell(2, G8, 20);
        dwell(3, G9, 20);
        idle(3);
        chk("t5_ovr", 32'(ovr_pulses - o0), 32'd1);
        chk("t5_held_data", 32'(frame_data), 32'hF7BA);
        chk("t5_held_valid", 32'(frame_valid), 32'h1);
        dwell(0, GC, 20);
        dwell(1, GD, 20);
        dwell(2, GE, 20);
        drive(3, G0);
        tick(9);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        chk("t5_third_valid", 32'(frame_valid), 32'h1);
        chk("t5_third_data", 32'(frame_data), 32'h0EDC);
        tick(10);
        idle(3);
        chk("t5_ovr_once", 32'(ovr_pulses - o0), 32'd1);
        chk("t5_still_valid", 32'(frame_valid), 32'h1);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        chk("t5_consumed", 32'(frame_valid), 32'h0);

        // Test 6: blank digit 1, then reset mid-scan with a frame held.
        dwell(0, G1, 20);
        dwell(1, GOFF, 20);
        dwell(2, G2, 20);
        dwell(3, G3, 20);
        idle(2);
        chk("t6_data", 32'(frame_data), 32'h3201);
        chk("t6_blank", 32'(frame_blank), 32'b0010);
        chk("t6_valid", 32'(frame_valid), 32'h1);
        dwell(0, G1, 20);
        dwell(1, G2, 20);
        chk("t6_mask_pre", 32'(dut.captured_q), 32'b0011);
        rst_n = 1'b0;
        idle(2);
        chk("t6_rst_data", 32'(frame_data), 32'h0);
        chk("t6_rst_blank", 32'(frame_blank), 32'h0);
        chk("t6_rst_valid", 32'(frame_valid), 32'h0);
        chk("t6_rst_err", 32'({pattern_err, frame_ovr}), 32'h0);
        chk("t6_rst_errcnt", 32'(err_count), 32'h0);
        chk("t6_rst_mask", 32'(dut.captured_q), 32'h0);
        chk("t6_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst_n = 1'b1;
        tick(2);
        dwell(2, G4, 20);
        dwell(3, G5, 20);
        idle(3);
        chk("t6_post_no_frame", 32'(frame_valid), 32'h0);
        chk("t6_post_mask", 32'(dut.captured_q), 32'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
